// File: rtl/mfp_ahb_uart_tx.sv
// ---------------------------------------------------------------------------
// mfp_ahb_uart_tx
//
// Transmit-only 8N1 console UART on an AHB-lite slave port. The CPU pushes
// bytes into a small TX buffer. A baud-rate state machine pops them and
// shifts them out LSB first on UART_TX. The slave never inserts wait
// states.
//
// Build option:
//   MFP_UART_TX_FIFO_EN  defined     : TX FIFO of depth 2**FIFO_AW
//                        not defined : single holding register (depth 1),
//                                      and FIFO_AW is ignored
//
// Parameters:
//   FIFO_AW      FIFO address width (depth = 2**FIFO_AW)
//   DEFAULT_DIV  reset value of BAUDDIV (bit period = BAUDDIV+1 cycles)
//
// Ports:
//   HCLK, HRESETn  clock, synchronous active-low reset
//   HADDR[1:0]     word offset (bus HADDR[3:2])
//   HTRANS[1:0]    transfer type, HTRANS[1]=1 marks a valid transfer
//   HWDATA[31:0]   write data (data phase)
//   HWRITE         1 = write
//   HSEL           slave select
//   HRDATA[31:0]   registered read data, valid in the data phase
//   UART_TX        serial output, idle high
//
// Register map (HADDR[3:2]):
//   0 TXDATA  (W)   push HWDATA[7:0], reads 0
//   1 STATUS  (R/W) [0] full [1] empty [2] busy [3] overflow [8:4] count;
//                   writing HWDATA[3]=1 clears overflow
//   2 BAUDDIV (R/W) [15:0] divisor
//   3 CTRL    (R/W) [0] enable
// ---------------------------------------------------------------------------
module mfp_ahb_uart_tx #(
    parameter int          FIFO_AW     = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [1:0]  HADDR,
    input  logic [1:0]  HTRANS,
    input  logic [31:0] HWDATA,
    input  logic        HWRITE,
    input  logic        HSEL,
    output logic [31:0] HRDATA,
    output logic        UART_TX
);

    typedef enum logic [1:0] {
        REG_TXDATA  = 2'd0,
        REG_STATUS  = 2'd1,
        REG_BAUDDIV = 2'd2,
        REG_CTRL    = 2'd3
    } reg_addr_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } tx_state_t;

    // Bus-side state
    logic        wr_pend;
    reg_addr_t   wr_addr;
    logic [15:0] baud_div;
    logic        enable;
    logic        overflow;

    // Buffer interface
    logic        push;
    logic        push_ok;
    logic        pop;
    logic        full;
    logic        empty;
    logic [7:0]  head;
    logic [4:0]  cnt_field;

    // Transmitter state
    tx_state_t   state;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;

    logic        rd_req;
    logic [31:0] rd_data;

    // Inputs that carry no information for this slave.
    logic unused_bits;
    assign unused_bits = &{1'b0, HTRANS[0], HWDATA[31:16], FIFO_AW[0]};

    assign rd_req  = HSEL & HTRANS[1] & ~HWRITE;
    assign push    = wr_pend && (wr_addr == REG_TXDATA);
    assign pop     = (state == S_IDLE) && enable && !empty;
    // A pop in the same cycle frees a slot, so a push into a full buffer is
    // still accepted then.
    assign push_ok = push && (!full || pop);

    // -----------------------------------------------------------------------
    // TX buffer
    // -----------------------------------------------------------------------
`ifdef MFP_UART_TX_FIFO_EN
    localparam int DEPTH = 1 << FIFO_AW;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wptr;
    logic [FIFO_AW-1:0] rptr;
    logic [FIFO_AW:0]   count;

    // count never exceeds DEPTH, so its MSB alone flags a full FIFO.
    assign full      = count[FIFO_AW];
    assign empty     = (count == '0);
    assign head      = mem[rptr];
    assign cnt_field = 5'(count);

    // NOTE: the storage array has no reset; its contents are only
    // meaningful below count, which is reset, and leaving it unreset lets
    // it map onto plain RAM.
    always_ff @(posedge HCLK) begin
        if (push_ok) begin
            mem[wptr] <= HWDATA[7:0];
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop)     rptr <= rptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
`else
    logic [7:0] hold_data;
    logic       hold_valid;

    assign full      = hold_valid;
    assign empty     = !hold_valid;
    assign head      = hold_data;
    assign cnt_field = {4'd0, hold_valid};

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            hold_valid <= 1'b0;
            hold_data  <= 8'd0;
        end else if (push_ok) begin
            hold_data  <= HWDATA[7:0];
            hold_valid <= 1'b1;
        end else if (pop) begin
            hold_valid <= 1'b0;
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Read mux
    // -----------------------------------------------------------------------
    // NOTE: every output of a combinational block gets a default first, so
    // that no path through the case leaves it unassigned (which infers a latch).
    always_comb begin
        rd_data = 32'd0;
        case (reg_addr_t'(HADDR))
            REG_STATUS:  rd_data = {23'd0, cnt_field, overflow,
                                    (state != S_IDLE), empty, full};
            REG_BAUDDIV: rd_data = {16'd0, baud_div};
            REG_CTRL:    rd_data = {31'd0, enable};
            default:     rd_data = 32'd0;
        endcase
    end

    // -----------------------------------------------------------------------
    // AHB slave: address phase latches the write, the data phase applies it
    // -----------------------------------------------------------------------
    // NOTE: state is updated with non-blocking assignments, so every block
    // sees the pre-edge value of every register regardless of evaluation
    // order.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            wr_pend  <= 1'b0;
            wr_addr  <= REG_TXDATA;
            HRDATA   <= 32'd0;
            baud_div <= DEFAULT_DIV;
            enable   <= 1'b1;
            overflow <= 1'b0;
        end else begin
            wr_pend <= HSEL & HTRANS[1] & HWRITE;
            wr_addr <= reg_addr_t'(HADDR);

            if (rd_req) begin
                HRDATA <= rd_data;
            end

            if (wr_pend) begin
                case (wr_addr)
                    REG_STATUS:  if (HWDATA[3]) overflow <= 1'b0;
                    REG_BAUDDIV: baud_div <= HWDATA[15:0];
                    REG_CTRL:    enable   <= HWDATA[0];
                    default:     ;
                endcase
            end

            if (push && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Transmitter. baud_cnt is reloaded from baud_div at every bit start, so
    // each state lasts baud_div+1 cycles and a new divisor takes effect at
    // the next bit boundary.
    // -----------------------------------------------------------------------
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state    <= S_IDLE;
            baud_cnt <= 16'd0;
            bit_idx  <= 3'd0;
            shreg    <= 8'd0;
            UART_TX  <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    UART_TX <= 1'b1;
                    if (pop) begin
                        state    <= S_START;
                        baud_cnt <= baud_div;
                        shreg    <= head;
                        UART_TX  <= 1'b0;
                    end
                end
                S_START: begin
                    if (baud_cnt == 16'd0) begin
                        state    <= S_DATA;
                        baud_cnt <= baud_div;
                        bit_idx  <= 3'd0;
                        UART_TX  <= shreg[0];
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                S_DATA: begin
                    if (baud_cnt == 16'd0) begin
                        baud_cnt <= baud_div;
                        if (bit_idx == 3'd7) begin
                            state   <= S_STOP;
                            UART_TX <= 1'b1;
                        end else begin
                            // shreg[0] is the bit on the line; shift the next one in.
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= {1'b0, shreg[7:1]};
                            UART_TX <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                S_STOP: begin
                    if (baud_cnt == 16'd0) begin
                        state <= S_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    UART_TX <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mfp_ahb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_mfp_ahb_uart_tx
//
// Directed self-checking bench for mfp_ahb_uart_tx. Inputs are driven on
// the falling edge of HCLK and outputs are sampled on the falling edge.
// Expectations depend on MFP_UART_TX_FIFO_EN, which must match the RTL
// build.
// ---------------------------------------------------------------------------
module tb_mfp_ahb_uart_tx;

    localparam logic [1:0] A_TXDATA  = 2'd0;
    localparam logic [1:0] A_STATUS  = 2'd1;
    localparam logic [1:0] A_BAUDDIV = 2'd2;
    localparam logic [1:0] A_CTRL    = 2'd3;

    logic        HCLK;
    logic        HRESETn;
    logic [1:0]  HADDR;
    logic [1:0]  HTRANS;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic        HSEL;
    logic [31:0] HRDATA;
    logic        UART_TX;

    int checks = 0;
    int errors = 0;

    mfp_ahb_uart_tx #(
        .FIFO_AW     (4),
        .DEFAULT_DIV (16'd433)
    ) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .HADDR   (HADDR),
        .HTRANS  (HTRANS),
        .HWDATA  (HWDATA),
        .HWRITE  (HWRITE),
        .HSEL    (HSEL),
        .HRDATA  (HRDATA),
        .UART_TX (UART_TX)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge HCLK);
    endtask

    // Address phase on one cycle and data phase on the next. Returns before
    // the data-phase edge, at which the write takes effect.
    task automatic ahb_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
        @(negedge HCLK);
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
    endtask

    task automatic ahb_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
        @(negedge HCLK);
        HSEL = 1'b0; HTRANS = 2'b00;
        d = HRDATA;
    endtask

    task automatic check_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] d;
        ahb_read(a, d);
        check(tag, 64'(d), 64'(exp));
    endtask

`ifdef MFP_UART_TX_FIFO_EN
    // Pipelined TXDATA writes, one per cycle: the data phase of write i
    // overlaps the address phase of write i+1.
    task automatic tx_burst(input int n, input logic [7:0] base);
        for (int i = 0; i <= n; i++) begin
            @(negedge HCLK);
            if (i > 0) HWDATA = 32'(base + 8'(i - 1));
            if (i < n) begin
                HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = A_TXDATA;
            end else begin
                HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
            end
        end
    endtask
`endif

    initial begin
        logic [39:0] wave;
        logic [31:0] d;
        int          lows;

        HRESETn = 1'b0;
        HADDR = 2'd0; HTRANS = 2'b00; HWDATA = 32'd0; HWRITE = 1'b0; HSEL = 1'b0;
        idle(3);
        HRESETn = 1'b1;

        // ---- reset values
        check("rst_hrdata", 64'(HRDATA), 64'h0);
        check("rst_tx", 64'(UART_TX), 64'h1);
        check_reg("rst_status", A_STATUS, 32'h002);
        check_reg("rst_bauddiv", A_BAUDDIV, 32'd433);
        check_reg("rst_ctrl", A_CTRL, 32'h1);
        check_reg("rst_txdata_reads0", A_TXDATA, 32'h0);

        // ---- single frame of 0x55, 4 cycles per bit
        ahb_write(A_BAUDDIV, 32'hFFFF_0003);
        check_reg("bauddiv_rw", A_BAUDDIV, 32'h3);
        ahb_write(A_TXDATA, 32'h55);
        @(negedge HCLK);                       // after data edge: not yet popped
        check("tx_before_pop", 64'(UART_TX), 64'h1);
        for (int j = 0; j < 40; j++) begin
            @(negedge HCLK);
            wave[j] = UART_TX;
        end
        // start 0, data 1010_1010 LSB first, stop 1; 4 samples per bit
        check("frame_55", 64'(wave), 64'h00_F0F0_F0F0F0);
        @(negedge HCLK);
        check("tx_idle_after", 64'(UART_TX), 64'h1);
        check_reg("status_done", A_STATUS, 32'h002);

        // ---- busy during a frame
        ahb_write(A_TXDATA, 32'hA3);
        idle(1);
        check_reg("status_busy", A_STATUS, 32'h006);
        idle(45);
        check_reg("status_busy_done", A_STATUS, 32'h002);

        // ---- buffer fills during a frame, then overflow and clear
        ahb_write(A_TXDATA, 32'h11);
        idle(2);
        ahb_write(A_TXDATA, 32'h22);
`ifdef MFP_UART_TX_FIFO_EN
        check_reg("hold_second", A_STATUS, 32'h014);
        ahb_write(A_TXDATA, 32'h33);
        check_reg("third_queued", A_STATUS, 32'h024);
        ahb_write(A_STATUS, 32'h8);
        check_reg("third_after_clr", A_STATUS, 32'h024);
        idle(150);
`else
        check_reg("hold_second", A_STATUS, 32'h015);
        ahb_write(A_TXDATA, 32'h33);
        check_reg("third_overflow", A_STATUS, 32'h01D);
        ahb_write(A_STATUS, 32'h8);
        check_reg("overflow_clr", A_STATUS, 32'h015);
        idle(100);
`endif
        check_reg("hold_drained", A_STATUS, 32'h002);

`ifdef MFP_UART_TX_FIFO_EN
        // ---- 17 back-to-back writes into a depth-16 FIFO, first frame running
        ahb_write(A_BAUDDIV, 32'h1);
        tx_burst(17, 8'h40);
        check_reg("burst17_no_ovf", A_STATUS, 32'h105);
        ahb_write(A_TXDATA, 32'h99);
        check_reg("burst18_ovf", A_STATUS, 32'h10D);
        ahb_write(A_STATUS, 32'h8);
        ahb_read(A_STATUS, d);
        check("burst_ovf_clr", 64'(d[3]), 64'h0);
        idle(400);
        check_reg("burst_drained", A_STATUS, 32'h002);
        ahb_write(A_BAUDDIV, 32'h3);
`endif

        // ---- enable=0 holds data in the buffer
        ahb_write(A_CTRL, 32'h0);
        check_reg("ctrl_off", A_CTRL, 32'h0);
        ahb_write(A_TXDATA, 32'h01);
`ifdef MFP_UART_TX_FIFO_EN
        ahb_write(A_TXDATA, 32'h02);
        ahb_write(A_TXDATA, 32'h03);
        idle(5);
        check("dis_tx_high", 64'(UART_TX), 64'h1);
        check_reg("dis_count3", A_STATUS, 32'h030);
        ahb_write(A_CTRL, 32'h1);
        idle(1);
        check_reg("en_popped", A_STATUS, 32'h024);
        idle(140);
`else
        idle(5);
        check("dis_tx_high", 64'(UART_TX), 64'h1);
        check_reg("dis_held", A_STATUS, 32'h011);
        ahb_write(A_TXDATA, 32'h02);
        check_reg("dis_overflow", A_STATUS, 32'h019);
        ahb_write(A_STATUS, 32'h8);
        check_reg("dis_ovf_clr", A_STATUS, 32'h011);
        ahb_write(A_CTRL, 32'h1);
        idle(1);
        check_reg("en_popped", A_STATUS, 32'h006);
        idle(60);
`endif
        check_reg("en_drained", A_STATUS, 32'h002);

        // ---- clearing enable mid-frame: frame completes, no further pop
        ahb_write(A_TXDATA, 32'hC4);
        ahb_write(A_TXDATA, 32'h5A);
        ahb_write(A_CTRL, 32'h0);
        idle(60);
        check("midoff_tx_high", 64'(UART_TX), 64'h1);
`ifdef MFP_UART_TX_FIFO_EN
        check_reg("midoff_status", A_STATUS, 32'h010);
`else
        check_reg("midoff_status", A_STATUS, 32'h011);
`endif
        ahb_write(A_CTRL, 32'h1);
        idle(60);
        check_reg("midoff_resumed", A_STATUS, 32'h002);

        // ---- reset in the middle of DATA
        ahb_write(A_TXDATA, 32'h00);
        ahb_write(A_TXDATA, 32'h77);
        idle(8);
        check("mid_data_low", 64'(UART_TX), 64'h0);
        HRESETn = 1'b0;
        @(negedge HCLK);
        check("rst_mid_tx", 64'(UART_TX), 64'h1);
        HRESETn = 1'b1;
        check_reg("rst_mid_status", A_STATUS, 32'h002);
        check_reg("rst_mid_bauddiv", A_BAUDDIV, 32'd433);
        lows = 0;
        for (int j = 0; j < 60; j++) begin
            @(negedge HCLK);
            if (UART_TX !== 1'b1) lows++;
        end
        check("rst_mid_no_frame", 64'(lows), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
